// File: rtl/fifo_axis_packetizer.sv
// Drains a first-word-fall-through FIFO read port into an AXI-Stream master.
// One word is held back so tlast lands on the true last word of a packet.
// A packet closes at MAX_PKT words, after TIMEOUT idle cycles, or on flush.
module fifo_axis_packetizer #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned MAX_PKT = 64,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  localparam int unsigned BEAT_W = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_PKT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

  logic              hold_valid;
  logic [DWIDTH-1:0] hold_data;
  logic [BEAT_W-1:0] beat_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              flush_pend;

  logic out_free;
  logic last_beat;
  logic timed_out;
  logic do_release;
  logic close_pkt;
  logic pop;

  // Release/pop decisions; pop is also the combinational FIFO read strobe.
  always_comb begin
    out_free   = ~m_axis_tvalid | m_axis_tready;
    last_beat  = (beat_cnt == LAST_BEAT);
    timed_out  = (idle_cnt == IDLE_MAX);
    close_pkt  = last_beat | fifo_rd_empty | flush_pend | flush;
    do_release = hold_valid & out_free &
                 (~fifo_rd_empty | last_beat | timed_out | flush_pend | flush);
    pop        = ~rst & ~fifo_rd_empty & (~hold_valid | do_release);
    fifo_rd_en = pop;
  end

  // Output register and per-packet beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      beat_cnt      <= '0;
    end else if (do_release) begin
      m_axis_tdata  <= hold_data;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= close_pkt;
      beat_cnt      <= close_pkt ? '0 : beat_cnt + BEAT_W'(1);
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Hold register, idle timer and sticky flush request.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      idle_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (pop) begin
        hold_data  <= fifo_rd_data;
        hold_valid <= 1'b1;
      end else if (do_release) begin
        hold_valid <= 1'b0;
      end

      if (~hold_valid | pop | do_release) begin
        idle_cnt <= '0;
      end else if (fifo_rd_empty && !timed_out) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      if (do_release) begin
        flush_pend <= 1'b0;
      end else if (hold_valid && flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_axis_packetizer.sv
// Bench for fifo_axis_packetizer: queue-based FIFO model feeding the DUT,
// scoreboard of expected {data, tlast} beats checked at the AXI-Stream side.
module tb_fifo_axis_packetizer;

  localparam int unsigned DW   = 32;
  localparam int          MAXP = 64;
  localparam int          TMO  = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int            nwords;
    logic [DW-1:0] base;
    bit            rnd_ready;
    int            exp_lasts;
    int            first_lat;
    int            rate_words;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_empty;
  logic          fifo_rd_en;
  logic          flush;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;

  logic [DW-1:0] fifo_q[$];
  beat_t         exp_q[$];
  vec_t          vecs[5];

  int checks, failures, cyc;
  int pop_total, acc_total, last_cnt, bp, bo;
  int pop_cyc[256];
  int out_cyc[256];
  bit pop_seen, prev_rst, prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  fifo_axis_packetizer #(
    .DWIDTH (DW),
    .MAX_PKT(MAXP),
    .TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_en   (fifo_rd_en),
    .flush        (flush),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic fifo_drive();
    fifo_rd_empty = (fifo_q.size() == 0);
    fifo_rd_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input bit last);
    beat_t b;
    b.data = d;
    b.last = last;
    fifo_q.push_back(d);
    exp_q.push_back(b);
  endtask

  // Mid-cycle observation of the DUT: pops, accepted beats, stall stability.
  task automatic sample();
    beat_t e;
    if (rst) begin
      check(fifo_rd_en == 1'b0, "rd_en_during_reset", 64'(fifo_rd_en), 64'd0);
      pop_seen   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_rst) begin
        check(m_axis_tvalid == 1'b0, "reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check(m_axis_tlast == 1'b0, "reset_tlast", 64'(m_axis_tlast), 64'd0);
        check(m_axis_tdata == '0, "reset_tdata", 64'(m_axis_tdata), 64'd0);
      end
      check(!(fifo_rd_en && fifo_rd_empty), "rd_en_when_empty", 64'(fifo_rd_en), 64'd0);
      pop_seen = fifo_rd_en;
      if (fifo_rd_en) begin
        pop_total++;
        if (bp < 256) pop_cyc[bp] = cyc;
        bp++;
      end
      if (prev_stall) begin
        check(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last,
              "stall_stability", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, prev_last, prev_data});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check(exp_q.size() != 0, "unexpected_beat", 64'(m_axis_tdata), 64'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(m_axis_tdata == e.data && m_axis_tlast == e.last, "beat_data_last",
                {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, e.last, e.data});
        end
        acc_total++;
        if (m_axis_tlast) last_cnt++;
        if (bo < 256) out_cyc[bo] = cyc;
        bo++;
      end
      prev_stall = m_axis_tvalid & ~m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
    prev_rst = rst;
  endtask

  // One clock: sample at negedge, then update the FIFO model after the edge.
  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    fifo_drive();
  endtask

  task automatic wait_idle(input bit rnd, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    m_axis_tready = 1'b1;
    check(exp_q.size() == 0, "drain_budget", 64'(exp_q.size()), 64'd0);
    repeat (TMO + 4) step();
  endtask

  initial begin
    int a0, p0, n, sp, late;
    checks = 0; failures = 0; cyc = 0;
    pop_total = 0; acc_total = 0; last_cnt = 0; bp = 0; bo = 0;
    pop_seen = 1'b0; prev_rst = 1'b0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    rst = 1'b1; flush = 1'b0; m_axis_tready = 1'b1;
    fifo_drive();

    // {nwords, base, random tready, tlast count, first-word latency, 1/cycle span}
    vecs[0] = '{130, 32'h0000_0000, 1'b0, 3, 2, 128};
    vecs[1] = '{1,   32'h0000_00A5, 1'b0, 1, TMO + 2, 0};
    vecs[2] = '{64,  32'h0000_1000, 1'b0, 1, 2, 64};
    vecs[3] = '{65,  32'h0000_2000, 1'b1, 2, 0, 0};
    vecs[4] = '{3,   32'h0000_3000, 1'b1, 1, 0, 0};

    // Reset held three cycles with the FIFO non-empty.
    for (int i = 0; i < 3; i++) push_word(32'h7000 + DW'(i), i == 2);
    fifo_drive();
    repeat (3) step();
    rst = 1'b0;
    wait_idle(1'b0, 500);

    // Table-driven bursts.
    foreach (vecs[v]) begin
      bp = 0; bo = 0; last_cnt = 0;
      for (int i = 0; i < vecs[v].nwords; i++)
        push_word(vecs[v].base + DW'(i), ((i % MAXP) == MAXP - 1) || (i == vecs[v].nwords - 1));
      fifo_drive();
      wait_idle(vecs[v].rnd_ready, 3000);
      check(last_cnt == vecs[v].exp_lasts, "burst_tlast_count", 64'(last_cnt), 64'(vecs[v].exp_lasts));
      if (!vecs[v].rnd_ready && vecs[v].first_lat != 0)
        check(out_cyc[0] - pop_cyc[0] == vecs[v].first_lat, "first_word_latency",
              64'(out_cyc[0] - pop_cyc[0]), 64'(vecs[v].first_lat));
      if (!vecs[v].rnd_ready && vecs[v].rate_words != 0)
        check(out_cyc[vecs[v].rate_words - 1] - out_cyc[0] == vecs[v].rate_words - 1, "throughput_span",
              64'(out_cyc[vecs[v].rate_words - 1] - out_cyc[0]), 64'(vecs[v].rate_words - 1));
    end

    // Back-pressure: 10-cycle stall mid-stream.
    a0 = acc_total;
    for (int i = 0; i < 30; i++) push_word(32'h6000 + DW'(i), i == 29);
    fifo_drive();
    n = 0;
    while (acc_total - a0 < 5 && n < 200) begin step(); n++; end
    m_axis_tready = 1'b0;
    sp = 0; late = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (pop_seen) begin
        sp++;
        if (k > 0) late++;
      end
    end
    m_axis_tready = 1'b1;
    check(sp <= 1, "stall_pop_count", 64'(sp), 64'd1);
    check(late == 0, "stall_late_pops", 64'(late), 64'd0);
    wait_idle(1'b0, 1000);

    // Flush while word 5 is held and the FIFO still supplies data.
    p0 = pop_total; last_cnt = 0;
    for (int i = 0; i < MAXP + 8; i++)
      push_word(32'h8000 + DW'(i), (i == 5) || (i == MAXP + 5) || (i == MAXP + 7));
    fifo_drive();
    n = 0;
    while (pop_total - p0 < 6 && n < 200) begin step(); n++; end
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_idle(1'b0, 1000);
    check(last_cnt == 3, "flush_tlast_count", 64'(last_cnt), 64'd3);

    // Flush with nothing held produces no output.
    a0 = acc_total;
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (20) step();
    check(acc_total == a0, "flush_empty_no_output", 64'(acc_total - a0), 64'd0);

    // Reset in the middle of a packet; fresh traffic afterwards.
    a0 = acc_total;
    for (int i = 0; i < 20; i++) push_word(32'h4000 + DW'(i), i == 19);
    fifo_drive();
    n = 0;
    while (acc_total - a0 < 10 && n < 200) begin step(); n++; end
    check(acc_total - a0 == 10, "mid_reset_progress", 64'(acc_total - a0), 64'd10);
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    fifo_drive();
    repeat (2) step();
    rst = 1'b0;
    last_cnt = 0;
    for (int i = 0; i < MAXP + 3; i++)
      push_word(32'h5000 + DW'(i), (i == MAXP - 1) || (i == MAXP + 2));
    fifo_drive();
    wait_idle(1'b0, 2000);
    check(last_cnt == 2, "post_reset_tlast_count", 64'(last_cnt), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
